// File: rtl/qa_driver_pkg.sv
// Shared types and sizing helpers for the QA driver shim chain.
package qa_driver_pkg;

  localparam int unsigned C1_DATA_W = 512;
  localparam int unsigned C1_HDR_W  = 61;

  typedef struct packed {
    logic                 isIrq;
    logic [C1_HDR_W-1:0]  hdr;
    logic [C1_DATA_W-1:0] data;
  } t_c1_tx_entry;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int unsigned countWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qa_fifo_sc.sv
// Single-clock FIFO with wrapping pointers and an entry count; head is read combinationally.
module qa_fifo_sc
  import qa_driver_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData_c,
  output logic [countWidth(DEPTH)-1:0] count,
  output logic                         full_c,
  output logic                         empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = countWidth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full_c    = (count == CNT_W'(DEPTH));
  assign empty_c   = (count == '0);
  assign doPush    = push & ~full_c;
  assign doPop     = pop & ~empty_c;
  assign popData_c = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/qa_shim_c1_tx_buffer.sv
// C1 TX buffer shim: absorbs AFU write/interrupt requests and forwards them in order to the QLP.
module qa_shim_c1_tx_buffer
  import qa_driver_pkg::*;
#(
  parameter int unsigned CCI_DATA_WIDTH   = C1_DATA_W,
  parameter int unsigned CCI_TX_HDR_WIDTH = C1_HDR_W,
  parameter int unsigned DEPTH            = 64,
  parameter int unsigned ALMFULL_SLACK    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CCI_TX_HDR_WIDTH-1:0]   afu_C1TxHdr,
  input  logic [CCI_DATA_WIDTH-1:0]     afu_C1TxData,
  input  logic                          afu_C1TxWrValid,
  input  logic                          afu_C1TxIrValid,
  output logic                          afu_C1TxAlmFull,
  output logic [CCI_TX_HDR_WIDTH-1:0]   qlp_C1TxHdr,
  output logic [CCI_DATA_WIDTH-1:0]     qlp_C1TxData,
  output logic                          qlp_C1TxWrValid,
  output logic                          qlp_C1TxIrValid,
  input  logic                          qlp_C1TxAlmFull,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          err_overflow,
  output logic                          err_dual_valid
);

  localparam int unsigned ENTRY_W   = 1 + CCI_TX_HDR_WIDTH + CCI_DATA_WIDTH;
  localparam int unsigned CNT_W     = countWidth(DEPTH);
  localparam int unsigned ALM_LEVEL = DEPTH - ALMFULL_SLACK;

  logic               anyValid;
  logic               pushQ;
  logic               popQ;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   nextCount;
  logic [ENTRY_W-1:0] pushEntry;
  logic [ENTRY_W-1:0] headEntry;
  logic               headIsIrq;
  logic [CCI_TX_HDR_WIDTH-1:0] headHdr;
  logic [CCI_DATA_WIDTH-1:0]   headData;

  // A dual-valid cycle is stored as a write; the interrupt is discarded.
  assign anyValid  = afu_C1TxWrValid | afu_C1TxIrValid;
  assign pushEntry = {afu_C1TxIrValid & ~afu_C1TxWrValid, afu_C1TxHdr, afu_C1TxData};

  assign headIsIrq = headEntry[ENTRY_W-1];
  assign headHdr   = headEntry[CCI_DATA_WIDTH +: CCI_TX_HDR_WIDTH];
  assign headData  = headEntry[CCI_DATA_WIDTH-1:0];

  assign pushQ     = anyValid & ~fifoFull;
  assign popQ      = ~fifoEmpty & ~qlp_C1TxAlmFull;
  assign nextCount = count + CNT_W'(pushQ) - CNT_W'(popQ);
  assign occupancy = count;

  qa_fifo_sc #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pushQ),
    .pushData  (pushEntry),
    .pop       (popQ),
    .popData_c (headEntry),
    .count     (count),
    .full_c    (fifoFull),
    .empty_c   (fifoEmpty)
  );

  // Output stage, almost-full and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qlp_C1TxWrValid <= 1'b0;
      qlp_C1TxIrValid <= 1'b0;
      afu_C1TxAlmFull <= 1'b0;
      err_overflow    <= 1'b0;
      err_dual_valid  <= 1'b0;
    end else begin
      qlp_C1TxWrValid <= popQ & ~headIsIrq;
      qlp_C1TxIrValid <= popQ & headIsIrq;
      afu_C1TxAlmFull <= (nextCount >= CNT_W'(ALM_LEVEL));
      if (anyValid & fifoFull)                   err_overflow   <= 1'b1;
      if (afu_C1TxWrValid & afu_C1TxIrValid)     err_dual_valid <= 1'b1;
    end
  end

  // Payload only needs to be meaningful alongside a valid.
  always_ff @(posedge clk) begin
    if (popQ) begin
      qlp_C1TxHdr  <= headHdr;
      qlp_C1TxData <= headData;
    end
  end

endmodule

// File: tb/tb_qa_shim_c1_tx_buffer.sv
// Directed self-checking bench for qa_shim_c1_tx_buffer (DEPTH=64, ALMFULL_SLACK=4).
module tb_qa_shim_c1_tx_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [60:0]  afu_C1TxHdr = '0;
  logic [511:0] afu_C1TxData = '0;
  logic         afu_C1TxWrValid = 1'b0;
  logic         afu_C1TxIrValid = 1'b0;
  logic         afu_C1TxAlmFull;
  logic [60:0]  qlp_C1TxHdr;
  logic [511:0] qlp_C1TxData;
  logic         qlp_C1TxWrValid;
  logic         qlp_C1TxIrValid;
  logic         qlp_C1TxAlmFull = 1'b0;
  logic [6:0]   occupancy;
  logic         err_overflow;
  logic         err_dual_valid;

  int passCnt = 0;
  int totalCnt = 0;

  logic [60:0] recHdr [$];
  bit          recIrq [$];
  int          bothSeen = 0;

  qa_shim_c1_tx_buffer #(
    .CCI_DATA_WIDTH   (512),
    .CCI_TX_HDR_WIDTH (61),
    .DEPTH            (64),
    .ALMFULL_SLACK    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .afu_C1TxHdr     (afu_C1TxHdr),
    .afu_C1TxData    (afu_C1TxData),
    .afu_C1TxWrValid (afu_C1TxWrValid),
    .afu_C1TxIrValid (afu_C1TxIrValid),
    .afu_C1TxAlmFull (afu_C1TxAlmFull),
    .qlp_C1TxHdr     (qlp_C1TxHdr),
    .qlp_C1TxData    (qlp_C1TxData),
    .qlp_C1TxWrValid (qlp_C1TxWrValid),
    .qlp_C1TxIrValid (qlp_C1TxIrValid),
    .qlp_C1TxAlmFull (qlp_C1TxAlmFull),
    .occupancy       (occupancy),
    .err_overflow    (err_overflow),
    .err_dual_valid  (err_dual_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick and log whatever the QLP side emitted after that edge.
  task automatic tickRec();
    tick();
    if (qlp_C1TxWrValid && qlp_C1TxIrValid) bothSeen++;
    if (qlp_C1TxWrValid || qlp_C1TxIrValid) begin
      recHdr.push_back(qlp_C1TxHdr);
      recIrq.push_back(qlp_C1TxIrValid);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [511:0] pat(input int unsigned i);
    return {16{i}};
  endfunction

  initial begin
    logic [511:0] dead;
    int  outCnt;
    logic [60:0] lastHdr;
    bit  anyQlp;

    dead = {16{32'hDEADBEEF}};

    // Reset state
    tick();
    tick();
    chk("rst_wrvalid", qlp_C1TxWrValid, 1'b0);
    chk("rst_irvalid", qlp_C1TxIrValid, 1'b0);
    chk("rst_almfull", afu_C1TxAlmFull, 1'b0);
    chk("rst_occ", occupancy, 7'd0);
    chk("rst_errs", {err_overflow, err_dual_valid}, 2'b00);
    reset = 1'b0;
    tick();

    // Single write: valid exactly two cycles after push
    afu_C1TxHdr = 61'h1A5;
    afu_C1TxData = dead;
    afu_C1TxWrValid = 1'b1;
    tick();
    afu_C1TxWrValid = 1'b0;
    chk("single_n1_valid", qlp_C1TxWrValid, 1'b0);
    chk("single_n1_occ", occupancy, 7'd1);
    tick();
    chk("single_n2_valid", qlp_C1TxWrValid, 1'b1);
    chk("single_n2_irq", qlp_C1TxIrValid, 1'b0);
    chk("single_hdr", qlp_C1TxHdr, 61'h1A5);
    chk("single_data", qlp_C1TxData, dead);
    chk("single_occ", occupancy, 7'd0);
    tick();
    chk("single_n3_valid", qlp_C1TxWrValid, 1'b0);

    // Fill 60 under QLP back-pressure, almost-full threshold
    qlp_C1TxAlmFull = 1'b1;
    anyQlp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      afu_C1TxHdr = 61'(i);
      afu_C1TxData = pat(i);
      afu_C1TxWrValid = 1'b1;
      tick();
      anyQlp |= qlp_C1TxWrValid | qlp_C1TxIrValid;
      if (i == 58) chk("almfull_at59", afu_C1TxAlmFull, 1'b0);
    end
    afu_C1TxWrValid = 1'b0;
    chk("almfull_at60", afu_C1TxAlmFull, 1'b1);
    chk("fill60_occ", occupancy, 7'd60);
    chk("fill60_no_qlp", anyQlp, 1'b0);
    qlp_C1TxAlmFull = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      chk($sformatf("drain_valid_%0d", k), qlp_C1TxWrValid, 1'b1);
      chk($sformatf("drain_hdr_%0d", k), qlp_C1TxHdr, 61'(k));
      chk($sformatf("drain_data_%0d", k), qlp_C1TxData, pat(k));
    end
    tick();
    chk("drain_end_valid", qlp_C1TxWrValid, 1'b0);
    chk("drain_end_occ", occupancy, 7'd0);
    chk("drain_end_almfull", afu_C1TxAlmFull, 1'b0);

    // Overflow: push at full concurrent with a pop is dropped
    qlp_C1TxAlmFull = 1'b1;
    for (int i = 0; i < 64; i++) begin
      afu_C1TxHdr = 61'(100 + i);
      afu_C1TxData = pat(100 + i);
      afu_C1TxWrValid = 1'b1;
      tick();
    end
    chk("full_occ", occupancy, 7'd64);
    chk("full_err_clear", err_overflow, 1'b0);
    qlp_C1TxAlmFull = 1'b0;
    afu_C1TxHdr = 61'h999;
    tick();
    afu_C1TxWrValid = 1'b0;
    chk("ovf_occ", occupancy, 7'd63);
    chk("ovf_err", err_overflow, 1'b1);
    outCnt = 0;
    lastHdr = '0;
    if (qlp_C1TxWrValid) begin
      outCnt++;
      lastHdr = qlp_C1TxHdr;
    end
    for (int c = 0; c < 70; c++) begin
      tick();
      if (qlp_C1TxWrValid) begin
        outCnt++;
        lastHdr = qlp_C1TxHdr;
      end
    end
    chk("ovf_out_count", 32'(outCnt), 32'd64);
    chk("ovf_last_hdr", lastHdr, 61'd163);
    chk("ovf_sticky", err_overflow, 1'b1);
    chk("ovf_drain_occ", occupancy, 7'd0);
    doReset();
    chk("ovf_cleared_by_reset", err_overflow, 1'b0);

    // Interleaved write / interrupt / write ordering
    recHdr.delete();
    recIrq.delete();
    bothSeen = 0;
    afu_C1TxHdr = 61'hA; afu_C1TxWrValid = 1'b1; afu_C1TxIrValid = 1'b0;
    tickRec();
    afu_C1TxHdr = 61'hB; afu_C1TxWrValid = 1'b0; afu_C1TxIrValid = 1'b1;
    tickRec();
    afu_C1TxHdr = 61'hC; afu_C1TxWrValid = 1'b1; afu_C1TxIrValid = 1'b0;
    tickRec();
    afu_C1TxWrValid = 1'b0;
    for (int c = 0; c < 5; c++) tickRec();
    chk("ilv_count", 32'(recHdr.size()), 32'd3);
    chk("ilv_both", 32'(bothSeen), 32'd0);
    if (recHdr.size() == 3) begin
      chk("ilv_seq_hdr", {recHdr[0], recHdr[1], recHdr[2]}, {61'hA, 61'hB, 61'hC});
      chk("ilv_seq_irq", {recIrq[0], recIrq[1], recIrq[2]}, 3'b010);
    end
    chk("ilv_no_dual_err", err_dual_valid, 1'b0);

    // Both valids: write only, error flagged
    recHdr.delete();
    recIrq.delete();
    afu_C1TxHdr = 61'h3;
    afu_C1TxWrValid = 1'b1;
    afu_C1TxIrValid = 1'b1;
    tickRec();
    afu_C1TxWrValid = 1'b0;
    afu_C1TxIrValid = 1'b0;
    for (int c = 0; c < 5; c++) tickRec();
    chk("dual_count", 32'(recHdr.size()), 32'd1);
    if (recHdr.size() == 1) begin
      chk("dual_hdr", recHdr[0], 61'h3);
      chk("dual_is_write", recIrq[0], 1'b0);
    end
    chk("dual_err", err_dual_valid, 1'b1);
    chk("dual_no_ovf", err_overflow, 1'b0);

    // Async reset mid-operation discards buffered entries
    qlp_C1TxAlmFull = 1'b1;
    for (int i = 0; i < 21; i++) begin
      afu_C1TxHdr = 61'(200 + i);
      afu_C1TxWrValid = 1'b1;
      tick();
    end
    afu_C1TxWrValid = 1'b0;
    qlp_C1TxAlmFull = 1'b0;
    tick();
    qlp_C1TxAlmFull = 1'b1;
    chk("midrst_pre_valid", qlp_C1TxWrValid, 1'b1);
    chk("midrst_pre_occ", occupancy, 7'd20);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_async_valid", {qlp_C1TxWrValid, qlp_C1TxIrValid}, 2'b00);
    chk("midrst_async_occ", occupancy, 7'd0);
    chk("midrst_async_errs", {afu_C1TxAlmFull, err_overflow, err_dual_valid}, 3'b000);
    tick();
    reset = 1'b0;
    qlp_C1TxAlmFull = 1'b0;
    anyQlp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      anyQlp |= qlp_C1TxWrValid | qlp_C1TxIrValid;
    end
    chk("midrst_no_stale", anyQlp, 1'b0);
    chk("midrst_occ", occupancy, 7'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
